// File: rtl/dual_lane_serializer.sv
// dual_lane_serializer
// Two-lane parallel-to-serial transmitter. One word per lane is taken through
// a valid/ready handshake. The word is shifted out MSB first, one bit per
// clock, and both lanes stay in lockstep. Back-to-back words go out with no
// idle gap.
//
// Optional feature: when the macro SER_PARITY_EN is defined, each frame ends
// with one even-parity bit per lane, so a frame is WIDTH+1 bits long.
//
// Ports:
//   clk        clock, all state updates on posedge
//   arst       asynchronous reset, active-high
//   in_valid   in_data_a/in_data_b hold a valid word
//   in_ready   word can be accepted this cycle (combinational)
//   in_data_a  parallel word, lane a
//   in_data_b  parallel word, lane b
//   ser_a      serial bit, lane a
//   ser_b      serial bit, lane b
//   ser_valid  ser_a/ser_b carry a valid bit
//   ser_last   current bit is the final bit of the frame
//   busy       a frame is being shifted out
module dual_lane_serializer #(
    parameter int unsigned WIDTH = 2,
    parameter int unsigned CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             arst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data_a,
    input  logic [WIDTH-1:0] in_data_b,
    output logic             ser_a,
    output logic             ser_b,
    output logic             ser_valid,
    output logic             ser_last,
    output logic             busy
);

`ifdef SER_PARITY_EN
    localparam int unsigned FRAME_W = WIDTH + 1;
`else
    localparam int unsigned FRAME_W = WIDTH;
`endif
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_W - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t state;
    state_t state_nxt;

    // The register holds the bits still to be sent. The bit on the wire sits in ser_*.
    logic [FRAME_W-1:0] sh_a;
    logic [FRAME_W-1:0] sh_b;
    logic [CNT_W-1:0]   cnt;

    logic [FRAME_W-1:0] frame_a;
    logic [FRAME_W-1:0] frame_b;
    logic [FRAME_W-1:0] sh_a_nxt;
    logic [FRAME_W-1:0] sh_b_nxt;
    logic [CNT_W-1:0]   cnt_nxt;
    logic               ser_a_nxt;
    logic               ser_b_nxt;
    logic               ser_valid_nxt;
    logic               ser_last_nxt;
    logic               ready_int;
    logic               accept;

    // Handshake. Reset does not enter here; the flops are held by arst anyway.
    assign ready_int = (state == IDLE) || ((state == SHIFT) && ser_last);
    assign accept    = in_valid && ready_int;

    // State register
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = SHIFT;
            SHIFT:   if (ser_last && !accept) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Output decode. in_ready is held low while reset is asserted.
    always_comb begin
        in_ready = 1'b0;
        busy     = 1'b0;
        in_ready = ready_int && !arst;
        busy     = (state == SHIFT);
    end

    // Frame assembly. Any parity bits are computed from the word as it is accepted.
    always_comb begin
        frame_a = '0;
        frame_b = '0;
`ifdef SER_PARITY_EN
        frame_a = {in_data_a, ^in_data_a};
        frame_b = {in_data_b, ^in_data_b};
`else
        frame_a = in_data_a;
        frame_b = in_data_b;
`endif
    end

    // Datapath next values: load on accept, shift in SHIFT, clear at end of frame
    always_comb begin
        sh_a_nxt      = sh_a;
        sh_b_nxt      = sh_b;
        cnt_nxt       = cnt;
        ser_a_nxt     = ser_a;
        ser_b_nxt     = ser_b;
        ser_valid_nxt = ser_valid;
        ser_last_nxt  = ser_last;
        if (accept) begin
            ser_a_nxt     = frame_a[FRAME_W-1];
            ser_b_nxt     = frame_b[FRAME_W-1];
            sh_a_nxt      = {frame_a[FRAME_W-2:0], 1'b0};
            sh_b_nxt      = {frame_b[FRAME_W-2:0], 1'b0};
            cnt_nxt       = '0;
            ser_valid_nxt = 1'b1;
            ser_last_nxt  = (LAST_CNT == '0);
        end else if (state == SHIFT) begin
            if (ser_last) begin
                sh_a_nxt      = '0;
                sh_b_nxt      = '0;
                cnt_nxt       = '0;
                ser_a_nxt     = 1'b0;
                ser_b_nxt     = 1'b0;
                ser_valid_nxt = 1'b0;
                ser_last_nxt  = 1'b0;
            end else begin
                ser_a_nxt    = sh_a[FRAME_W-1];
                ser_b_nxt    = sh_b[FRAME_W-1];
                sh_a_nxt     = {sh_a[FRAME_W-2:0], 1'b0};
                sh_b_nxt     = {sh_b[FRAME_W-2:0], 1'b0};
                cnt_nxt      = cnt + CNT_W'(1);
                ser_last_nxt = ((cnt + CNT_W'(1)) == LAST_CNT);
            end
        end
    end

    // Datapath registers
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            sh_a      <= '0;
            sh_b      <= '0;
            cnt       <= '0;
            ser_a     <= 1'b0;
            ser_b     <= 1'b0;
            ser_valid <= 1'b0;
            ser_last  <= 1'b0;
        end else begin
            sh_a      <= sh_a_nxt;
            sh_b      <= sh_b_nxt;
            cnt       <= cnt_nxt;
            ser_a     <= ser_a_nxt;
            ser_b     <= ser_b_nxt;
            ser_valid <= ser_valid_nxt;
            ser_last  <= ser_last_nxt;
        end
    end

endmodule
